// File: rtl/hs_tx_sequencer.sv
// hs_tx_sequencer
// High-speed transmit sequencer for one D-PHY data lane. It frames an HS burst
// as HS-prepare zeros, the SoT sync word, payload words and the HS trailer. It
// drives the lane's downstream 2:1 word mux (s=1 selects a, s=0 selects b).
//
// Ports:
//   clk           lane byte clock; all logic is on the rising edge
//   rst           synchronous, active-high reset
//   tx_request_hs burst request; also acts as the data-valid
//   tx_data_hs    payload word, captured when accepted
//   tx_ready_hs   combinational; 1 = tx_data_hs is accepted at this edge
//   mux_a         framing word (prepare zeros, sync word, trailer)
//   mux_b         registered payload word
//   mux_s         mux select; 1 = framing (a), 0 = payload (b)
//   hs_active     lane is in HS mode (PREP through TRAILER)
module hs_tx_sequencer #(
  parameter int          W         = 8,
  parameter logic [W-1:0] SYNC_WORD = 8'hB8,
  parameter int          T_PREP    = 4,
  parameter int          T_TRAIL   = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tx_request_hs,
  input  logic [W-1:0] tx_data_hs,
  output logic         tx_ready_hs,
  output logic [W-1:0] mux_a,
  output logic [W-1:0] mux_b,
  output logic         mux_s,
  output logic         hs_active
);

  localparam int T_MAX = (T_PREP > T_TRAIL) ? T_PREP : T_TRAIL;
  localparam int CW    = $clog2(T_MAX) + 1;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    SYNC,
    DATA,
    TRAILER,
    EXIT
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   mux_b_q, mux_b_d;
  logic           last_bit_q, last_bit_d;

  // State, phase counter, payload register and the last serialized bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mux_b_q    <= '0;
      last_bit_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mux_b_q    <= mux_b_d;
      last_bit_q <= last_bit_d;
    end
  end

  // Next-state logic. The counter restarts at zero on every state entry, so
  // each timed phase ends when the counter reaches its length minus one.
  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    mux_b_d    = mux_b_q;
    last_bit_d = last_bit_q;

    unique case (state_q)
      IDLE: begin
        if (tx_request_hs) begin
          state_d = PREP;
        end
      end
      PREP: begin
        if (cnt_q == CW'(T_PREP - 1)) begin
          state_d = SYNC;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SYNC: begin
        if (tx_request_hs) begin
          mux_b_d = tx_data_hs;
          state_d = DATA;
        end else begin
          last_bit_d = SYNC_WORD[W-1];
          state_d    = TRAILER;
        end
      end
      DATA: begin
        if (tx_request_hs) begin
          mux_b_d = tx_data_hs;
        end else begin
          // Words go out LSB first, so the MSB is the final bit on the wire
          // and the trailer must drive its complement.
          last_bit_d = mux_b_q[W-1];
          state_d    = TRAILER;
        end
      end
      TRAILER: begin
        if (cnt_q == CW'(T_TRAIL - 1)) begin
          state_d = EXIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      EXIT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Moore-decoded mux controls; ready is the only input-dependent output.
  always_comb begin
    mux_a       = '0;
    mux_s       = 1'b1;
    hs_active   = 1'b0;
    tx_ready_hs = 1'b0;

    unique case (state_q)
      IDLE: begin
      end
      PREP: begin
        hs_active = 1'b1;
      end
      SYNC: begin
        mux_a       = SYNC_WORD;
        hs_active   = 1'b1;
        tx_ready_hs = tx_request_hs;
      end
      DATA: begin
        mux_s       = 1'b0;
        hs_active   = 1'b1;
        tx_ready_hs = tx_request_hs;
      end
      TRAILER: begin
        mux_a     = {W{~last_bit_q}};
        hs_active = 1'b1;
      end
      EXIT: begin
      end
      default: begin
      end
    endcase
  end

  assign mux_b = mux_b_q;

endmodule

// File: tb/tb_hs_tx_sequencer.sv
// tb_hs_tx_sequencer
// Drives directed burst scenarios followed by randomized requests, resets and
// payloads. The reference model describes a burst as a timeline: position t
// counts cycles since the burst started, the phase follows from where t sits
// relative to the prepare length, the sync slot and the cycle on which the
// payload ended.
module tb_hs_tx_sequencer;

  localparam int         W         = 8;
  localparam logic [7:0] SYNC_WORD = 8'hB8;
  localparam int         T_PREP    = 4;
  localparam int         T_TRAIL   = 4;

  localparam int PH_IDLE  = 0;
  localparam int PH_PREP  = 1;
  localparam int PH_SYNC  = 2;
  localparam int PH_DATA  = 3;
  localparam int PH_TRAIL = 4;
  localparam int PH_EXIT  = 5;

  logic         clk;
  logic         rst;
  logic         tx_request_hs;
  logic [W-1:0] tx_data_hs;
  logic         tx_ready_hs;
  logic [W-1:0] mux_a;
  logic [W-1:0] mux_b;
  logic         mux_s;
  logic         hs_active;

  int total = 0;
  int bad   = 0;

  // Reference model of the burst timeline.
  bit         m_busy      = 1'b0;
  int         m_t         = 0;
  bit         m_data_open = 1'b0;
  int         m_trail_at  = 0;
  logic       m_last_bit  = 1'b0;
  logic [7:0] m_b         = 8'h00;
  bit         m_valid     = 1'b0;

  hs_tx_sequencer #(
    .W         (W),
    .SYNC_WORD (SYNC_WORD),
    .T_PREP    (T_PREP),
    .T_TRAIL   (T_TRAIL)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .tx_request_hs (tx_request_hs),
    .tx_data_hs    (tx_data_hs),
    .tx_ready_hs   (tx_ready_hs),
    .mux_a         (mux_a),
    .mux_b         (mux_b),
    .mux_s         (mux_s),
    .hs_active     (hs_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed,
               expected, $time);
    end
  endtask

  function automatic int model_phase();
    int u;
    if (!m_busy) return PH_IDLE;
    if (m_t < T_PREP) return PH_PREP;
    if (m_t == T_PREP) return PH_SYNC;
    if (m_data_open) return PH_DATA;
    u = m_t - m_trail_at;
    if (u < T_TRAIL) return PH_TRAIL;
    return PH_EXIT;
  endfunction

  // One clock cycle: drive inputs, compare outputs against the model, then
  // advance the model by the edge that consumes those inputs.
  task automatic applyStimulus(input logic r, input logic req,
                               input logic [7:0] data);
    int ph;
    @(negedge clk);
    rst           = r;
    tx_request_hs = req;
    tx_data_hs    = data;
    #1;
    ph = model_phase();
    if (m_valid) begin
      case (ph)
        PH_IDLE: begin
          checkOutput("idle_s",   32'(mux_s),       32'd1);
          checkOutput("idle_a",   32'(mux_a),       32'h00);
          checkOutput("idle_act", 32'(hs_active),   32'd0);
          checkOutput("idle_rdy", 32'(tx_ready_hs), 32'd0);
        end
        PH_PREP: begin
          checkOutput("prep_s",   32'(mux_s),       32'd1);
          checkOutput("prep_a",   32'(mux_a),       32'h00);
          checkOutput("prep_act", 32'(hs_active),   32'd1);
          checkOutput("prep_rdy", 32'(tx_ready_hs), 32'd0);
        end
        PH_SYNC: begin
          checkOutput("sync_s",   32'(mux_s),       32'd1);
          checkOutput("sync_a",   32'(mux_a),       32'(SYNC_WORD));
          checkOutput("sync_act", 32'(hs_active),   32'd1);
          checkOutput("sync_rdy", 32'(tx_ready_hs), 32'(req));
        end
        PH_DATA: begin
          checkOutput("data_s",   32'(mux_s),       32'd0);
          checkOutput("data_act", 32'(hs_active),   32'd1);
          checkOutput("data_rdy", 32'(tx_ready_hs), 32'(req));
        end
        PH_TRAIL: begin
          checkOutput("trail_s",   32'(mux_s),       32'd1);
          checkOutput("trail_a",   32'(mux_a),       32'({8{~m_last_bit}}));
          checkOutput("trail_act", 32'(hs_active),   32'd1);
          checkOutput("trail_rdy", 32'(tx_ready_hs), 32'd0);
        end
        default: begin
          checkOutput("exit_s",   32'(mux_s),       32'd1);
          checkOutput("exit_a",   32'(mux_a),       32'h00);
          checkOutput("exit_act", 32'(hs_active),   32'd0);
          checkOutput("exit_rdy", 32'(tx_ready_hs), 32'd0);
        end
      endcase
      checkOutput("mux_b", 32'(mux_b), 32'(m_b));
    end
    @(posedge clk);
    if (r) begin
      m_busy      = 1'b0;
      m_data_open = 1'b0;
      m_b         = 8'h00;
      m_valid     = 1'b1;
    end else if (m_valid) begin
      case (ph)
        PH_IDLE: begin
          if (req) begin
            m_busy      = 1'b1;
            m_t         = 0;
            m_data_open = 1'b0;
          end
        end
        PH_SYNC, PH_DATA: begin
          if (req) begin
            m_b         = data;
            m_data_open = 1'b1;
          end else begin
            m_last_bit  = (ph == PH_SYNC) ? SYNC_WORD[7] : m_b[7];
            m_data_open = 1'b0;
            m_trail_at  = m_t + 1;
          end
          m_t++;
        end
        PH_EXIT: m_busy = 1'b0;
        default: m_t++;
      endcase
    end
  endtask

  task automatic idle_cycles(input int n, input logic req);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, req, 8'h00);
  endtask

  initial begin
    rst           = 1'b1;
    tx_request_hs = 1'b1;
    tx_data_hs    = 8'h00;

    // Reset held with the request high, then a three-word burst.
    applyStimulus(1'b1, 1'b1, 8'h00);
    applyStimulus(1'b1, 1'b1, 8'h00);
    idle_cycles(5, 1'b1);
    applyStimulus(1'b0, 1'b1, 8'h11);
    applyStimulus(1'b0, 1'b1, 8'h22);
    applyStimulus(1'b0, 1'b1, 8'h83);
    idle_cycles(8, 1'b0);

    // Single word with a clear MSB gives an all-ones trailer.
    idle_cycles(5, 1'b1);
    applyStimulus(1'b0, 1'b1, 8'h7F);
    idle_cycles(8, 1'b0);

    // Request held only in IDLE: empty burst, trailer follows the sync word.
    applyStimulus(1'b0, 1'b1, 8'h00);
    idle_cycles(12, 1'b0);

    // Reset in the second DATA cycle, request kept high afterwards.
    idle_cycles(5, 1'b1);
    applyStimulus(1'b0, 1'b1, 8'hAA);
    applyStimulus(1'b0, 1'b1, 8'hBB);
    applyStimulus(1'b1, 1'b1, 8'hCC);
    idle_cycles(5, 1'b1);
    applyStimulus(1'b0, 1'b1, 8'h5A);
    idle_cycles(8, 1'b0);

    // Request re-raised during the trailer and held into the next burst.
    applyStimulus(1'b0, 1'b1, 8'h00);
    idle_cycles(6, 1'b0);
    idle_cycles(9, 1'b1);
    applyStimulus(1'b0, 1'b1, 8'h3C);
    applyStimulus(1'b0, 1'b1, 8'hC3);
    idle_cycles(8, 1'b0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                    8'($urandom));
    end
    idle_cycles(12, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hs_tx_sequencer.md
Name: hs_tx_sequencer

Overview:
High-speed transmit sequencer for one D-PHY data lane, sitting directly upstream of the lane's W-bit 2:1 output mux (a/b/s/c; s=1 selects a, s=0 selects b). It runs the HS burst framing: HS-prepare zeros, the SoT sync word, the payload bytes with a PPI-style request/ready handshake, and the HS trailer. It drives mux input a (framing words), mux input b (payload) and the select s.

Parameters:
W, 8, lane word width; matches the downstream mux width.
SYNC_WORD, 8'hB8, SoT leader sequence; W bits.
T_PREP, 4, HS-prepare length in cycles; must be >= 1.
T_TRAIL, 4, HS-trailer length in cycles; must be >= 1.

Ports:
clk  in  1  lane byte clock; all logic is on the rising edge.
rst  in  1  synchronous, active-high reset.
tx_request_hs  in  1  burst request; also acts as the data-valid.
tx_data_hs  in  W  payload word; sampled on acceptance.
tx_ready_hs  out  1  combinational; 1 = tx_data_hs is accepted at this edge.
mux_a  out  W  framing word to mux input a.
mux_b  out  W  registered payload word to mux input b.
mux_s  out  1  mux select; 1 = framing (a), 0 = payload (b).
hs_active  out  1  lane is in HS mode (PREP..TRAILER).

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- rst=1 at an edge forces, from the next cycle: state=IDLE, counter=0, mux_a=0, mux_b=0, mux_s=1, hs_active=0, tx_ready_hs=0. This applies in any state, mid-burst included, and overrides all other inputs.
- States: IDLE, PREP, SYNC, DATA, TRAILER, EXIT. mux_s, mux_a and hs_active are Moore-decoded from the registered state.
- IDLE:
  - mux_s=1, mux_a=0, hs_active=0.
  - tx_request_hs=1 -> PREP with counter=0.
- PREP:
  - mux_s=1, mux_a=0, hs_active=1.
  - Lasts exactly T_PREP cycles and ignores tx_request_hs, then -> SYNC.
- SYNC (exactly 1 cycle):
  - mux_s=1, mux_a=SYNC_WORD, hs_active=1.
  - tx_ready_hs = tx_request_hs.
  - req=1: word accepted, mux_b<=tx_data_hs, -> DATA.
  - req=0: -> TRAILER, last_bit<=SYNC_WORD[W-1].
- DATA:
  - mux_s=0, mux_b holds the word accepted at the previous edge, hs_active=1.
  - tx_ready_hs = tx_request_hs.
  - req=1: accept, mux_b<=tx_data_hs, stay in DATA. One word per cycle; no stalls once the burst has started.
  - req=0: -> TRAILER, last_bit<=mux_b[W-1]. Bits are serialized LSB first, so the MSB is the last bit sent.
- Acceptance-to-mux_b latency is 1 cycle. tx_ready_hs=0 in every state other than SYNC and DATA.
- TRAILER:
  - mux_s=1, mux_a={W{~last_bit}}, hs_active=1.
  - Lasts exactly T_TRAIL cycles and ignores tx_request_hs, then -> EXIT.
- EXIT (1 cycle):
  - mux_s=1, mux_a=0, hs_active=0.
  - Always -> IDLE. A request held through EXIT is sampled first in IDLE, so a new burst starts PREP one cycle later.
- mux_b keeps its last value outside DATA; it is only changed by acceptance or reset.
- Counter width is $clog2(max(T_PREP,T_TRAIL))+1. It clears on each state entry.
- Minimum burst duration is T_PREP+1+T_TRAIL+1 cycles, with zero payload words.

Test Plan:
1. Assert rst for 2 cycles with tx_request_hs=1 -> mux_s=1, mux_a=00, mux_b=00, hs_active=0, tx_ready_hs=0 throughout. Release rst -> PREP begins at the next edge.
2. tx_request_hs=1 with words 0x11, 0x22, 0x83, then drop the request -> sequence:
   - 4 cycles mux_a=00, s=1;
   - 1 cycle mux_a=B8, s=1, tx_ready_hs=1;
   - mux_b=11, 22, 83 with s=0;
   - 4 cycles mux_a=00, s=1 (last_bit=1);
   - 1 EXIT cycle with hs_active=0.
   The muxed output c matches this sequence.
3. Single word 0x7F, request dropped next cycle -> one DATA cycle with mux_b=7F, then 4 trailer cycles with mux_a=FF.
4. Request held for only 1 cycle in IDLE (low by SYNC) -> full 4-cycle PREP, SYNC cycle with tx_ready_hs=0, no DATA cycle, trailer 00 for 4 cycles, EXIT.
5. rst=1 during the 2nd DATA cycle -> next cycle IDLE with all outputs at reset values. Request held high afterwards -> clean restart with PREP.
6. Request re-raised during TRAILER and held -> trailer completes all 4 cycles, EXIT, one IDLE cycle, then a new PREP; no word is accepted before SYNC.
